// File: rtl/pipe_branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters; 0-cycle lookup, 1-edge update.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module pipe_branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] pred_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    output logic [31:0]       stat_lookup_o,
    output logic [31:0]       stat_update_o,
    output logic [31:0]       stat_mispred_o
);

    // state   | meaning
    // ST_INIT | walking initialiser clears one entry per cycle; lookups miss, updates dropped
    // ST_RUN  | table live; clear_i restarts the initialiser from entry 0

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_idx_q, init_idx_d;
    logic               init_we;
    logic               run;

    logic               valid_mem  [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [ADDR_W-1:0]  target_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem    [ENTRIES];

    logic [IDX_W-1:0]   pred_idx;
    logic [TAG_W-1:0]   pred_tag;
    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic               upd_accept;
    logic [CTR_W-1:0]   upd_ctr;
    logic [CTR_W-1:0]   ctr_inc;
    logic [CTR_W-1:0]   ctr_dec;
    logic [CTR_W-1:0]   ctr_weak;

    assign run     = (state_q == ST_RUN);
    assign ready_o = run;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        init_we    = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we    = 1'b1;
                init_idx_d = init_idx_q + IDX_W'(1);
                if (init_idx_q == IDX_W'(ENTRIES - 1)) begin
                    state_d    = ST_RUN;
                    init_idx_d = '0;
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    state_d    = ST_INIT;
                    init_idx_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_idx_d = '0;
            end
        endcase
    end

    assign pred_idx      = pred_pc_i[IDX_W+1:2];
    assign pred_tag      = pred_pc_i[ADDR_W-1:IDX_W+2];
    assign pred_hit_o    = run & valid_mem[pred_idx] & (tag_mem[pred_idx] == pred_tag);
    assign pred_taken_o  = pred_hit_o & ctr_mem[pred_idx][CTR_W-1];
    assign pred_target_o = pred_taken_o ? target_mem[pred_idx] : (pred_pc_i + ADDR_W'(4));

    assign upd_idx    = upd_pc_i[IDX_W+1:2];
    assign upd_tag    = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign upd_hit    = valid_mem[upd_idx] & (tag_mem[upd_idx] == upd_tag);
    assign upd_ctr    = ctr_mem[upd_idx];
    // An update in the same cycle clear_i is accepted is dropped, not deferred.
    assign upd_accept = run & upd_valid_i & ~clear_i;
    assign ctr_inc    = (upd_ctr == {CTR_W{1'b1}}) ? upd_ctr : (upd_ctr + CTR_W'(1));
    assign ctr_dec    = (upd_ctr == '0) ? upd_ctr : (upd_ctr - CTR_W'(1));
    assign ctr_weak   = CTR_W'(1) << (CTR_W - 1);

    // Storage has no reset: the initialiser clears valid and ctr after every reset or clear.
    always_ff @(posedge clk_i) begin
        if (init_we) begin
            valid_mem[init_idx_q] <= 1'b0;
            ctr_mem[init_idx_q]   <= '0;
        end else if (upd_accept) begin
            if (upd_hit) begin
                if (upd_taken_i) begin
                    ctr_mem[upd_idx]    <= ctr_inc;
                    target_mem[upd_idx] <= upd_target_i;
                end else begin
                    ctr_mem[upd_idx] <= ctr_dec;
                end
            end else if (upd_taken_i) begin
                valid_mem[upd_idx]  <= 1'b1;
                tag_mem[upd_idx]    <= upd_tag;
                target_mem[upd_idx] <= upd_target_i;
                ctr_mem[upd_idx]    <= ctr_weak;
            end
        end
    end

`ifdef BP_STATS_EN
    logic        upd_pred_dir;
    logic        upd_mispred;
    logic [31:0] stat_lookup_q;
    logic [31:0] stat_update_q;
    logic [31:0] stat_mispred_q;

    assign upd_pred_dir = upd_hit & upd_ctr[CTR_W-1];
    assign upd_mispred  = (upd_pred_dir != upd_taken_i) |
                          (upd_pred_dir & upd_taken_i & (target_mem[upd_idx] != upd_target_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_lookup_q  <= '0;
            stat_update_q  <= '0;
            stat_mispred_q <= '0;
        end else if (run && clear_i) begin
            stat_lookup_q  <= '0;
            stat_update_q  <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (run) begin
                stat_lookup_q <= stat_lookup_q + 32'd1;
            end
            if (upd_accept) begin
                stat_update_q <= stat_update_q + 32'd1;
            end
            if (upd_accept && upd_mispred) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    assign stat_lookup_o  = stat_lookup_q;
    assign stat_update_o  = stat_update_q;
    assign stat_mispred_o = stat_mispred_q;
`else
    assign stat_lookup_o  = '0;
    assign stat_update_o  = '0;
    assign stat_mispred_o = '0;
`endif

endmodule

// File: tb/tb_pipe_branch_predictor.sv
// Scoreboard bench for pipe_branch_predictor: stimulus queues expectations, a negedge monitor checks them.
module tb_pipe_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        ready_o;
    logic [31:0] pred_pc_i;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic [31:0] stat_lookup_o;
    logic [31:0] stat_update_o;
    logic [31:0] stat_mispred_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        sb_q[$];
    chk_t        cur;
    logic [31:0] act;

    pipe_branch_predictor #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .ready_o       (ready_o),
        .pred_pc_i     (pred_pc_i),
        .pred_hit_o    (pred_hit_o),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i),
        .stat_lookup_o (stat_lookup_o),
        .stat_update_o (stat_update_o),
        .stat_mispred_o(stat_mispred_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return {31'b0, pred_hit_o};
            1:       return {31'b0, pred_taken_o};
            2:       return pred_target_o;
            3:       return {31'b0, ready_o};
            4:       return stat_lookup_o;
            5:       return stat_update_o;
            default: return stat_mispred_o;
        endcase
    endfunction

    always @(negedge clk_i) begin
        while (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            act = actual(cur.sel);
            checks++;
            if (act !== cur.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", cur.name, act, cur.exp);
            end
        end
    end

    task automatic expect_val(input string n, input int sel, input logic [31:0] v);
        chk_t c;
        c.name = n;
        c.sel  = sel;
        c.exp  = v;
        sb_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic look(input string n, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] tgt);
        pred_pc_i = pc;
        expect_val({n, "_hit"}, 0, {31'b0, hit});
        expect_val({n, "_taken"}, 1, {31'b0, tk});
        expect_val({n, "_target"}, 2, tgt);
    endtask

    task automatic exp_stats(input string n, input int l, input int u, input int m);
`ifdef BP_STATS_EN
        expect_val({n, "_stat_lookup"}, 4, l);
        expect_val({n, "_stat_update"}, 5, u);
        expect_val({n, "_stat_mispred"}, 6, m);
`else
        expect_val({n, "_stat_lookup"}, 4, 32'd0);
        expect_val({n, "_stat_update"}, 5, 32'd0);
        expect_val({n, "_stat_mispred"}, 6, 32'd0);
`endif
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_valid_i  = 1'b1;
        upd_pc_i     = pc;
        upd_taken_i  = tk;
        upd_target_i = tgt;
        tick();
        upd_valid_i  = 1'b0;
    endtask

    task automatic init_window(input string n, input logic [31:0] pc);
        for (int i = 0; i < 16; i++) begin
            expect_val($sformatf("%s_ready_lo%0d", n, i), 3, 32'd0);
            if (i == 0) look({n, "_miss"}, pc, 1'b0, 1'b0, pc + 32'd4);
            tick();
        end
        expect_val({n, "_ready_hi"}, 3, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b0;
        clear_i      = 1'b0;
        pred_pc_i    = 32'h40;
        upd_valid_i  = 1'b0;
        upd_pc_i     = '0;
        upd_taken_i  = 1'b0;
        upd_target_i = '0;
        #1;
        expect_val("rst_ready", 3, 32'd0);
        look("rst_lookup", 32'h40, 1'b0, 1'b0, 32'h44);
        exp_stats("rst", 0, 0, 0);
        tick();
        tick();
        rst_i = 1'b1;
        init_window("init", 32'h40);

        // First taken update seen by a same-cycle lookup only on the next cycle.
        look("same_cycle", 32'h40, 1'b0, 1'b0, 32'h44);
        do_upd(32'h40, 1'b1, 32'h100);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        do_upd(32'h40, 1'b0, 32'h0);
        look("ctr1", 32'h40, 1'b1, 1'b0, 32'h44);
        do_upd(32'h40, 1'b0, 32'h0);
        look("ctr0", 32'h40, 1'b1, 1'b0, 32'h44);
        do_upd(32'h40, 1'b1, 32'h100);
        look("ctr0_to_1", 32'h40, 1'b1, 1'b0, 32'h44);
        do_upd(32'h40, 1'b1, 32'h100);
        look("ctr2", 32'h40, 1'b1, 1'b1, 32'h100);
        do_upd(32'h40, 1'b1, 32'h100);
        do_upd(32'h40, 1'b1, 32'h100);
        look("ctr3_sat", 32'h40, 1'b1, 1'b1, 32'h100);
        do_upd(32'h40, 1'b0, 32'h0);
        look("sat_dec", 32'h40, 1'b1, 1'b1, 32'h100);

        // Aliasing at index 0, miss-not-taken leaves entry alone, separate index 1.
        do_upd(32'h80, 1'b1, 32'h200);
        look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
        do_upd(32'hC0, 1'b0, 32'h0);
        look("alias_new", 32'h80, 1'b1, 1'b1, 32'h200);
        do_upd(32'h44, 1'b1, 32'h300);
        look("idx1", 32'h44, 1'b1, 1'b1, 32'h300);
        tick();
        look("idx0_kept", 32'h80, 1'b1, 1'b1, 32'h200);

        // clear with a same-cycle update, a dropped update and an ignored clear inside INIT.
        expect_val("clr_ready_before", 3, 32'd1);
        clear_i      = 1'b1;
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h48;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h400;
        tick();
        clear_i     = 1'b0;
        upd_valid_i = 1'b0;
        exp_stats("clr", 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            expect_val($sformatf("clr_ready_lo%0d", i), 3, 32'd0);
            if (i == 3) upd_valid_i = 1'b1;
            if (i == 5) clear_i = 1'b1;
            tick();
            upd_valid_i = 1'b0;
            clear_i     = 1'b0;
        end
        expect_val("clr_ready_hi", 3, 32'd1);
        look("clr_dropped", 32'h48, 1'b0, 1'b0, 32'h4C);
        exp_stats("run0", 0, 0, 0);
        do_upd(32'h48, 1'b0, 32'h0);
        look("clr_wiped", 32'h80, 1'b0, 1'b0, 32'h84);
        do_upd(32'h48, 1'b1, 32'h400);
        do_upd(32'h48, 1'b1, 32'h400);
        look("s_ctr3", 32'h48, 1'b1, 1'b1, 32'h400);
        exp_stats("three_upd", 3, 3, 1);
        do_upd(32'h48, 1'b1, 32'h500);
        look("s_retarget", 32'h48, 1'b1, 1'b1, 32'h500);
        exp_stats("four_upd", 4, 4, 2);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        exp_stats("clr2", 0, 0, 0);
        expect_val("clr2_ready", 3, 32'd0);
        tick();
        tick();
        tick();

        // Reset in the middle of INIT restarts the walk from entry 0.
        rst_i = 1'b0;
        #1;
        expect_val("mid_rst_ready", 3, 32'd0);
        look("mid_rst", 32'h48, 1'b0, 1'b0, 32'h4C);
        exp_stats("mid_rst", 0, 0, 0);
        tick();
        rst_i = 1'b1;
        init_window("reinit", 32'h48);
        look("reinit_miss", 32'h48, 1'b0, 1'b0, 32'h4C);

        @(negedge clk_i);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
